// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one cache request/response port between instruction fetch
// (requester 0) and the data stage (requester 1). A round-robin arbiter
// issues requests, a tag FIFO remembers the owner of every in-flight access,
// and responses are routed back to their owner in issue order.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_req_*             per-requester request channel (valid/addr/op/wdata)
//   o_req_ready         per-requester accept, only the selected bit can be set
//   o_resp_valid/data   per-requester response valid, shared response data
//   i_resp_ready        per-requester response accept
//   o_mem_*/i_mem_ready request channel to memory
//   i_mem_r*/o_mem_rready response channel from memory
//   o_outstanding       number of in-flight accesses
//   o_err               sticky flag: response received with nothing in flight
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   i_req_valid,
    output logic [1:0]                   o_req_ready,
    input  logic [ADDR_W-1:0]            i_req_addr0,
    input  logic [ADDR_W-1:0]            i_req_addr1,
    input  logic                         i_req_op0,
    input  logic                         i_req_op1,
    input  logic [DATA_W-1:0]            i_req_wdata0,
    input  logic [DATA_W-1:0]            i_req_wdata1,
    output logic [1:0]                   o_resp_valid,
    input  logic [1:0]                   i_resp_ready,
    output logic [DATA_W-1:0]            o_resp_data,
    output logic                         o_mem_valid,
    input  logic                         i_mem_ready,
    output logic [ADDR_W-1:0]            o_mem_addr,
    output logic                         o_mem_op,
    output logic [DATA_W-1:0]            o_mem_wdata,
    input  logic                         i_mem_rvalid,
    output logic                         o_mem_rready,
    input  logic [DATA_W-1:0]            i_mem_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   o_outstanding,
    output logic                         o_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic             r_last;
    logic [DEPTH-1:0] r_tags;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    logic w_sel;
    logic w_full;
    logic w_empty;
    logic w_head;
    logic w_push;
    logic w_pop;

    // Priority goes to the requester that was not granted last.
    always_comb begin
        w_sel = 1'b0;
        case (i_req_valid)
            2'b01:   w_sel = 1'b0;
            2'b10:   w_sel = 1'b1;
            2'b11:   w_sel = ~r_last;
            default: w_sel = 1'b0;
        endcase
    end

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_head  = r_tags[r_rd_ptr];

    // Full blocks issue even when a pop lands in the same cycle; the slot
    // freed by the pop is only reusable on the following cycle.
    always_comb begin
        o_mem_valid = i_req_valid[w_sel] & ~w_full;
        o_mem_addr  = '0;
        o_mem_op    = 1'b0;
        o_mem_wdata = '0;
        o_req_ready = 2'b00;
        if (o_mem_valid) begin
            o_mem_addr  = w_sel ? i_req_addr1  : i_req_addr0;
            o_mem_op    = w_sel ? i_req_op1    : i_req_op0;
            o_mem_wdata = w_sel ? i_req_wdata1 : i_req_wdata0;
            o_req_ready[w_sel] = i_mem_ready;
        end
    end

    // A response with nothing in flight is never accepted nor routed.
    always_comb begin
        o_resp_valid = 2'b00;
        o_resp_data  = '0;
        o_mem_rready = 1'b0;
        if (!w_empty) begin
            o_resp_valid[w_head] = i_mem_rvalid;
            o_resp_data          = i_mem_rdata;
            o_mem_rready         = i_resp_ready[w_head];
        end
    end

    assign w_push = o_mem_valid & i_mem_ready;
    assign w_pop  = i_mem_rvalid & o_mem_rready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last   <= 1'b1;
            r_tags   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_tags[r_wr_ptr] <= w_sel;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
                r_last           <= w_sel;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_mem_rvalid && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_outstanding = r_count;
    assign o_err         = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    localparam logic [31:0] A0  = 32'h0000_0100;
    localparam logic [31:0] A1  = 32'h0000_0200;
    localparam logic [31:0] WD0 = 32'h1111_0000;
    localparam logic [31:0] WD1 = 32'h5555_AAAA;

    logic              clk;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [ADDR_W-1:0] req_addr0, req_addr1;
    logic              req_op0, req_op1;
    logic [DATA_W-1:0] req_wdata0, req_wdata1;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_op;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic              mem_rready;
    logic [DATA_W-1:0] mem_rdata;
    logic [2:0]        outstanding;
    logic              err;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_addr0   (req_addr0),
        .i_req_addr1   (req_addr1),
        .i_req_op0     (req_op0),
        .i_req_op1     (req_op1),
        .i_req_wdata0  (req_wdata0),
        .i_req_wdata1  (req_wdata1),
        .o_resp_valid  (resp_valid),
        .i_resp_ready  (resp_ready),
        .o_resp_data   (resp_data),
        .o_mem_valid   (mem_valid),
        .i_mem_ready   (mem_ready),
        .o_mem_addr    (mem_addr),
        .o_mem_op      (mem_op),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rvalid  (mem_rvalid),
        .o_mem_rready  (mem_rready),
        .i_mem_rdata   (mem_rdata),
        .o_outstanding (outstanding),
        .o_err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic sb_owner[$];

    typedef struct {
        logic [1:0] rv;
        logic       rvalid;
        logic [1:0] rrdy;
        logic [1:0] exp_rdy;
        logic [1:0] exp_rspv;
        logic [2:0] exp_out;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_pop_check(input string nm);
        logic owner;
        if (sb_owner.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: actual=response required=no_outstanding_entry", nm);
        end else begin
            owner = sb_owner.pop_front();
            chk({nm, "_owner"}, resp_valid, owner ? 2'b10 : 2'b01);
            chk({nm, "_data"}, resp_data, mem_rdata);
        end
    endtask

    task automatic idle_inputs();
        req_valid  = 2'b00;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        resp_ready = 2'b00;
        mem_rdata  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        sb_owner.delete();
    endtask

    initial begin
        // cycle | req_valid rvalid resp_ready | req_ready resp_valid outstanding
        vecs[0]  = '{2'b11, 1'b0, 2'b11, 2'b01, 2'b00, 3'd0};
        vecs[1]  = '{2'b11, 1'b0, 2'b11, 2'b10, 2'b00, 3'd1};
        vecs[2]  = '{2'b11, 1'b0, 2'b11, 2'b01, 2'b00, 3'd2};
        vecs[3]  = '{2'b11, 1'b0, 2'b11, 2'b10, 2'b00, 3'd3};
        vecs[4]  = '{2'b00, 1'b1, 2'b11, 2'b00, 2'b01, 3'd4};
        vecs[5]  = '{2'b00, 1'b1, 2'b11, 2'b00, 2'b10, 3'd3};
        vecs[6]  = '{2'b00, 1'b1, 2'b11, 2'b00, 2'b01, 3'd2};
        vecs[7]  = '{2'b00, 1'b1, 2'b11, 2'b00, 2'b10, 3'd1};
        vecs[8]  = '{2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 3'd0};
        vecs[9]  = '{2'b10, 1'b0, 2'b11, 2'b10, 2'b00, 3'd0};
        vecs[10] = '{2'b01, 1'b1, 2'b11, 2'b01, 2'b10, 3'd1};
        vecs[11] = '{2'b00, 1'b1, 2'b11, 2'b00, 2'b01, 3'd1};
        vecs[12] = '{2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 3'd0};

        req_addr0  = A0;
        req_addr1  = A1;
        req_op0    = 1'b0;
        req_op1    = 1'b1;
        req_wdata0 = WD0;
        req_wdata1 = WD1;

        // reset and single read
        do_reset();
        #1;
        chk("rst_outstanding", outstanding, 3'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_resp_valid", resp_valid, 2'b00);
        chk("rst_mem_rready", mem_rready, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        req_valid = 2'b01;
        mem_ready = 1'b1;
        #1;
        chk("rd_mem_valid", mem_valid, 1'b1);
        chk("rd_mem_addr", mem_addr, A0);
        chk("rd_req_ready", req_ready, 2'b01);
        sb_owner.push_back(1'b0);
        tick();
        req_valid  = 2'b00;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        resp_ready = 2'b11;
        #1;
        chk("rd_outstanding_1", outstanding, 3'd1);
        chk("rd_resp_valid", resp_valid, 2'b01);
        chk("rd_resp_data", resp_data, 32'hDEAD_BEEF);
        sb_pop_check("rd_sb");
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk("rd_outstanding_0", outstanding, 3'd0);

        // contention and concurrent issue/response, table-driven
        do_reset();
        for (int i = 0; i < 13; i++) begin
            logic [31:0] exp_addr, exp_wd;
            logic        exp_op;
            req_valid  = vecs[i].rv;
            mem_ready  = 1'b1;
            mem_rvalid = vecs[i].rvalid;
            resp_ready = vecs[i].rrdy;
            mem_rdata  = 32'hA000_0000 + 32'(i);
            exp_addr   = (vecs[i].exp_rdy == 2'b01) ? A0  : (vecs[i].exp_rdy == 2'b10) ? A1  : 32'h0;
            exp_wd     = (vecs[i].exp_rdy == 2'b01) ? WD0 : (vecs[i].exp_rdy == 2'b10) ? WD1 : 32'h0;
            exp_op     = (vecs[i].exp_rdy == 2'b10);
            #1;
            chk($sformatf("vec%0d_outstanding", i), outstanding, vecs[i].exp_out);
            chk($sformatf("vec%0d_req_ready", i), req_ready, vecs[i].exp_rdy);
            chk($sformatf("vec%0d_mem_valid", i), mem_valid, |vecs[i].exp_rdy);
            chk($sformatf("vec%0d_mem_addr", i), mem_addr, exp_addr);
            chk($sformatf("vec%0d_mem_op", i), mem_op, exp_op);
            chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, exp_wd);
            chk($sformatf("vec%0d_resp_valid", i), resp_valid, vecs[i].exp_rspv);
            if (vecs[i].exp_rspv != 2'b00) sb_pop_check($sformatf("vec%0d_sb", i));
            if (vecs[i].exp_rdy != 2'b00) sb_owner.push_back(vecs[i].exp_rdy[1]);
            tick();
        end

        // full: pop does not free a slot for the same cycle
        do_reset();
        mem_ready  = 1'b1;
        resp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            req_valid = 2'b01;
            #1;
            chk($sformatf("full_fill%0d_req_ready", k), req_ready, 2'b01);
            chk($sformatf("full_fill%0d_outstanding", k), outstanding, 3'(k));
            sb_owner.push_back(1'b0);
            tick();
        end
        #1;
        chk("full_mem_valid", mem_valid, 1'b0);
        chk("full_req_ready", req_ready, 2'b00);
        chk("full_outstanding", outstanding, 3'd4);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5000_0001;
        #1;
        chk("full_pop_mem_valid", mem_valid, 1'b0);
        chk("full_pop_req_ready", req_ready, 2'b00);
        chk("full_pop_mem_rready", mem_rready, 1'b1);
        sb_pop_check("full_pop_sb");
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk("full_resume_outstanding", outstanding, 3'd3);
        chk("full_resume_mem_valid", mem_valid, 1'b1);
        chk("full_resume_req_ready", req_ready, 2'b01);
        sb_owner.push_back(1'b0);
        tick();
        req_valid = 2'b00;
        #1;
        chk("full_refill_outstanding", outstanding, 3'd4);
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h6000_0000 + 32'(k);
            #1;
            sb_pop_check($sformatf("full_drain%0d", k));
            tick();
        end
        mem_rvalid = 1'b0;
        #1;
        chk("full_drained_outstanding", outstanding, 3'd0);

        // backpressure on the head owner
        do_reset();
        mem_ready  = 1'b1;
        req_valid  = 2'b11;
        #1;
        chk("bp_grant0", req_ready, 2'b01);
        sb_owner.push_back(1'b0);
        tick();
        #1;
        chk("bp_grant1", req_ready, 2'b10);
        sb_owner.push_back(1'b1);
        tick();
        req_valid  = 2'b00;
        mem_rvalid = 1'b1;
        resp_ready = 2'b01;
        mem_rdata  = 32'h7000_0000;
        #1;
        chk("bp_first_rready", mem_rready, 1'b1);
        sb_pop_check("bp_first_sb");
        tick();
        mem_rdata = 32'h7000_0001;
        #1;
        chk("bp_hold_outstanding_a", outstanding, 3'd1);
        chk("bp_hold_rready_a", mem_rready, 1'b0);
        chk("bp_hold_resp_valid", resp_valid, 2'b10);
        tick();
        #1;
        chk("bp_hold_outstanding_b", outstanding, 3'd1);
        chk("bp_hold_rready_b", mem_rready, 1'b0);
        tick();
        resp_ready = 2'b10;
        #1;
        chk("bp_release_rready", mem_rready, 1'b1);
        sb_pop_check("bp_release_sb");
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk("bp_done_outstanding", outstanding, 3'd0);

        // stray response, sticky err, reset mid-transaction
        mem_rvalid = 1'b1;
        resp_ready = 2'b11;
        mem_rdata  = 32'h1234_5678;
        #1;
        chk("err_resp_valid", resp_valid, 2'b00);
        chk("err_mem_rready", mem_rready, 1'b0);
        chk("err_resp_data", resp_data, 32'h0);
        chk("err_before_edge", err, 1'b0);
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk("err_set", err, 1'b1);
        tick();
        #1;
        chk("err_held", err, 1'b1);
        req_valid = 2'b01;
        tick();
        tick();
        req_valid = 2'b00;
        #1;
        chk("err_inflight_outstanding", outstanding, 3'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb_owner.delete();
        #1;
        chk("rst_mid_outstanding", outstanding, 3'd0);
        chk("rst_mid_err", err, 1'b0);
        req_valid = 2'b11;
        #1;
        chk("rst_mid_first_grant", req_ready, 2'b01);
        chk("rst_mid_first_addr", mem_addr, A0);
        tick();
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
